alu_resp_checker: RTL and testbench

- Synthesizable response checker: the consuming end of the ALU stimulus/response interface.
- Samples each ALU transaction (operands, controls, DUT Out/Odd_parity/Invalid), computes the golden result internally, and compares one cycle later.
- Keeps pass/fail/invalid statistics under a small run-control FSM.
- Sits beside the Alu in bring-up and FPGA self-test builds; fed by any stimulus source.

---
 rtl/alu_resp_checker.sv | 198 +++++++++++++++++++
 tb/tb_alu_resp_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_resp_checker.sv
// alu_resp_checker: consuming end of the ALU stimulus/response interface.
// Golden-model compare, run-control FSM and saturating statistics.
// Optional macro ALU_CHK_PARITY_EN adds Odd_parity to the compare.
module alu_resp_checker #(
  parameter int bits         = 4,
  parameter int CNT_W        = 16,
  parameter int NUM_VEC      = 0,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [bits-1:0]  A,
  input  logic [bits-1:0]  B,
  input  logic             cin,
  input  logic             red_op_A,
  input  logic             red_op_B,
  input  logic             bypass_A,
  input  logic             bypass_B,
  input  logic [2:0]       opcode,
  input  logic [bits:0]    dut_out,
  input  logic             dut_odd_parity,
  input  logic             dut_invalid,
  output logic             chk_valid,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] inv_cnt,
  output logic [2:0]       last_fail_op,
  output logic [1:0]       state,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_HALT = 2'b11
  } state_t;

  localparam logic [31:0] NUM_VEC_M1 = 32'(NUM_VEC) - 32'd1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    else    return c + CNT_W'(1);
  endfunction

  function automatic logic odd_par(input logic [bits:0] v);
    return ^v;
  endfunction

  state_t           r_state;
  logic             r_chk_valid;
  logic             r_mismatch;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_inv_cnt;
  logic [2:0]       r_last_fail_op;
  logic             r_done;
  logic [31:0]      r_acc_cnt;

  logic [bits:0]    w_gold_out;
  logic             w_gold_inv;
  logic             w_gold_par;
  logic             w_mismatch;
  logic             w_accept;
  logic             w_clr_stats;

  // Golden ALU model: bypass beats the invalid check, which beats the opcode
  always_comb begin
    w_gold_out = '0;
    w_gold_inv = 1'b0;
    if (bypass_A) begin
      w_gold_out = {1'b0, A};
    end else if (bypass_B) begin
      w_gold_out = {1'b0, B};
    end else if (opcode[2:1] == 2'b11 ||
                 ((red_op_A || red_op_B) && opcode >= 3'b010)) begin
      w_gold_inv = 1'b1;
    end else begin
      case (opcode)
        3'b000: begin
          if (red_op_A)      w_gold_out = {{bits{1'b0}}, &A};
          else if (red_op_B) w_gold_out = {{bits{1'b0}}, &B};
          else               w_gold_out = {1'b0, A & B};
        end
        3'b001: begin
          if (red_op_A)      w_gold_out = {{bits{1'b0}}, ^A};
          else if (red_op_B) w_gold_out = {{bits{1'b0}}, ^B};
          else               w_gold_out = {1'b0, A ^ B};
        end
        3'b010:  w_gold_out = {1'b0, A} + {1'b0, B} + {{bits{1'b0}}, cin};
        3'b011:  w_gold_out = {1'b0, A} - {1'b0, B};
        3'b100:  w_gold_out = {1'b0, A[bits-2:0], A[bits-1]};
        3'b101:  w_gold_out = {1'b0, A[0], A[bits-1:1]};
        default: w_gold_out = '0;
      endcase
    end
  end

  assign w_gold_par = odd_par(w_gold_out);

`ifdef ALU_CHK_PARITY_EN
  assign w_mismatch = (dut_out != w_gold_out) | (dut_invalid != w_gold_inv) |
                      (dut_odd_parity != w_gold_par);
`else
  logic w_unused_par;
  assign w_unused_par = dut_odd_parity ^ w_gold_par;
  assign w_mismatch   = (dut_out != w_gold_out) | (dut_invalid != w_gold_inv);
`endif

  assign w_accept    = in_valid & (r_state == S_RUN) & ~clear;
  assign w_clr_stats = clear | (start & (r_state != S_RUN));

  // Compare stage, statistics and run-control FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_chk_valid    <= 1'b0;
      r_mismatch     <= 1'b0;
      r_err_sticky   <= 1'b0;
      r_pass_cnt     <= '0;
      r_fail_cnt     <= '0;
      r_inv_cnt      <= '0;
      r_last_fail_op <= 3'b000;
      r_done         <= 1'b0;
      r_acc_cnt      <= 32'd0;
    end else begin
      r_chk_valid <= w_accept;
      r_mismatch  <= w_accept & w_mismatch;

      if (w_clr_stats) begin
        r_err_sticky   <= 1'b0;
        r_pass_cnt     <= '0;
        r_fail_cnt     <= '0;
        r_inv_cnt      <= '0;
        r_last_fail_op <= 3'b000;
        r_acc_cnt      <= 32'd0;
      end else if (w_accept) begin
        r_acc_cnt <= r_acc_cnt + 32'd1;
        if (w_mismatch) begin
          r_fail_cnt     <= sat_inc(r_fail_cnt);
          r_err_sticky   <= 1'b1;
          r_last_fail_op <= opcode;
        end else begin
          r_pass_cnt <= sat_inc(r_pass_cnt);
        end
        if (w_gold_inv) r_inv_cnt <= sat_inc(r_inv_cnt);
      end

      if (clear) begin
        r_state <= S_IDLE;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) r_state <= S_RUN;
          end
          S_RUN: begin
            // HALT takes precedence when the last vector of a run also fails
            if (w_accept && w_mismatch && STOP_ON_FAIL != 0) begin
              r_state <= S_HALT;
              r_done  <= 1'b1;
            end else if (w_accept && NUM_VEC != 0 && r_acc_cnt == NUM_VEC_M1) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
          S_DONE, S_HALT: begin
            if (start) begin
              r_state <= S_RUN;
              r_done  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign chk_valid    = r_chk_valid;
  assign mismatch     = r_mismatch;
  assign err_sticky   = r_err_sticky;
  assign pass_cnt     = r_pass_cnt;
  assign fail_cnt     = r_fail_cnt;
  assign inv_cnt      = r_inv_cnt;
  assign last_fail_op = r_last_fail_op;
  assign state        = r_state;
  assign done         = r_done;

endmodule

// File: tb/tb_alu_resp_checker.sv
// Scoreboard bench for alu_resp_checker: three instances (default, NUM_VEC=4,
// CNT_W=2 with STOP_ON_FAIL=0) share operand buses; expectations are queued per instance.
module tb_alu_resp_checker;

  typedef struct packed {
    logic        mis;
    logic [15:0] pc;
    logic [15:0] fc;
    logic [15:0] ic;
    logic        err;
    logic [2:0]  lop;
    logic [1:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] stt = 3'b000, clr = 3'b000, iv = 3'b000;
  logic [3:0] a = 4'd0, b = 4'd0;
  logic cin = 1'b0, ra = 1'b0, rb = 1'b0, ba = 1'b0, bb = 1'b0;
  logic [2:0] op = 3'd0;
  logic [4:0] dout = 5'd0;
  logic dpar = 1'b0, dinv = 1'b0;

  logic [2:0] o_cv, o_mis, o_err, o_done;
  logic [2:0][2:0] o_lop;
  logic [2:0][1:0] o_st;
  logic [2:0][15:0] o_pc, o_fc, o_ic;
  logic [1:0] p2_pc, p2_fc, p2_ic;

  int total = 0;
  int bad = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  alu_resp_checker u0 (
    .clk(clk), .rst(rst), .start(stt[0]), .clear(clr[0]), .in_valid(iv[0]),
    .A(a), .B(b), .cin(cin), .red_op_A(ra), .red_op_B(rb), .bypass_A(ba), .bypass_B(bb),
    .opcode(op), .dut_out(dout), .dut_odd_parity(dpar), .dut_invalid(dinv),
    .chk_valid(o_cv[0]), .mismatch(o_mis[0]), .err_sticky(o_err[0]),
    .pass_cnt(o_pc[0]), .fail_cnt(o_fc[0]), .inv_cnt(o_ic[0]),
    .last_fail_op(o_lop[0]), .state(o_st[0]), .done(o_done[0]));

  alu_resp_checker #(.NUM_VEC(4)) u1 (
    .clk(clk), .rst(rst), .start(stt[1]), .clear(clr[1]), .in_valid(iv[1]),
    .A(a), .B(b), .cin(cin), .red_op_A(ra), .red_op_B(rb), .bypass_A(ba), .bypass_B(bb),
    .opcode(op), .dut_out(dout), .dut_odd_parity(dpar), .dut_invalid(dinv),
    .chk_valid(o_cv[1]), .mismatch(o_mis[1]), .err_sticky(o_err[1]),
    .pass_cnt(o_pc[1]), .fail_cnt(o_fc[1]), .inv_cnt(o_ic[1]),
    .last_fail_op(o_lop[1]), .state(o_st[1]), .done(o_done[1]));

  alu_resp_checker #(.CNT_W(2), .STOP_ON_FAIL(0)) u2 (
    .clk(clk), .rst(rst), .start(stt[2]), .clear(clr[2]), .in_valid(iv[2]),
    .A(a), .B(b), .cin(cin), .red_op_A(ra), .red_op_B(rb), .bypass_A(ba), .bypass_B(bb),
    .opcode(op), .dut_out(dout), .dut_odd_parity(dpar), .dut_invalid(dinv),
    .chk_valid(o_cv[2]), .mismatch(o_mis[2]), .err_sticky(o_err[2]),
    .pass_cnt(p2_pc), .fail_cnt(p2_fc), .inv_cnt(p2_ic),
    .last_fail_op(o_lop[2]), .state(o_st[2]), .done(o_done[2]));

  assign o_pc[2] = {14'd0, p2_pc};
  assign o_fc[2] = {14'd0, p2_fc};
  assign o_ic[2] = {14'd0, p2_ic};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  task automatic set_vec(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                         input logic vra, input logic vrb, input logic vba, input logic vbb,
                         input logic [2:0] vop, input logic [4:0] vout, input logic vinv);
    a = va; b = vb; cin = vc; ra = vra; rb = vrb; ba = vba; bb = vbb;
    op = vop; dout = vout; dinv = vinv; dpar = ^vout;
  endtask

  task automatic push(input int i, input logic mis, input int pc, input int fc, input int ic,
                      input logic err, input logic [2:0] lop, input logic [1:0] st);
    exp_t e;
    e = '{mis: mis, pc: 16'(pc), fc: 16'(fc), ic: 16'(ic), err: err, lop: lop, st: st};
    if (i == 0)      q0.push_back(e);
    else if (i == 1) q1.push_back(e);
    else             q2.push_back(e);
  endtask

  // Monitor: pops the oldest expectation of an instance whenever it presents chk_valid
  always @(negedge clk) begin : mon
    exp_t e, g;
    for (int i = 0; i < 3; i++) begin
      if (o_cv[i]) begin
        g = {o_mis[i], o_pc[i], o_fc[i], o_ic[i], o_err[i], o_lop[i], o_st[i]};
        total++;
        if (i == 0 && q0.size() != 0)      e = q0.pop_front();
        else if (i == 1 && q1.size() != 0) e = q1.pop_front();
        else if (i == 2 && q2.size() != 0) e = q2.pop_front();
        else begin
          bad++;
          $display("FAIL unexpected_chk u%0d got chk_valid=1 required no compare", i);
          continue;
        end
        if (g !== e) begin
          bad++;
          $display("FAIL chk_u%0d got mis=%0d pc=%0d fc=%0d ic=%0d err=%0d lop=%b st=%b required mis=%0d pc=%0d fc=%0d ic=%0d err=%0d lop=%b st=%b",
                   i, g.mis, g.pc, g.fc, g.ic, g.err, g.lop, g.st,
                   e.mis, e.pc, e.fc, e.ic, e.err, e.lop, e.st);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_u%0d", i),
            {o_cv[i], o_mis[i], o_err[i], o_done[i], o_pc[i], o_fc[i], o_ic[i], o_lop[i], o_st[i]},
            64'd0);

    // Instance 0: pass, invalid-match, then a mismatch that halts
    stt[0] = 1'b1; tick(); stt[0] = 1'b0;
    check("u0_run", {62'd0, o_st[0]}, 64'd1);
    iv[0] = 1'b1;
    set_vec(4'b0011, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'b01001, 1'b0);
    push(0, 1'b0, 1, 0, 0, 1'b0, 3'b000, 2'b01); tick();
    set_vec(4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 5'b00000, 1'b1);
    push(0, 1'b0, 2, 0, 1, 1'b0, 3'b000, 2'b01); tick();
    set_vec(4'b0011, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 5'b00000, 1'b0);
    push(0, 1'b1, 2, 1, 2, 1'b1, 3'b011, 2'b11); tick();
    set_vec(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'b01111, 1'b0);
    tick(); iv[0] = 1'b0; tick();
    check("u0_halt", {60'd0, o_done[0], o_err[0], o_st[0]}, 64'b1111);
    check("u0_pc_hold", {48'd0, o_pc[0]}, 64'd2);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    check("u0_clear", {o_err[0], o_done[0], o_pc[0], o_fc[0], o_ic[0], o_lop[0], o_st[0]}, 64'd0);

    // Instance 1: NUM_VEC=4 back-to-back, fifth vector ignored
    stt[1] = 1'b1; tick(); stt[1] = 1'b0;
    iv[1] = 1'b1;
    set_vec(4'b1100, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'b01000, 1'b0);
    push(1, 1'b0, 1, 0, 0, 1'b0, 3'b000, 2'b01); tick();
    set_vec(4'b0111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 5'b00001, 1'b0);
    push(1, 1'b0, 2, 0, 0, 1'b0, 3'b000, 2'b01); tick();
    set_vec(4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 5'b00011, 1'b0);
    push(1, 1'b0, 3, 0, 0, 1'b0, 3'b000, 2'b01); tick();
    set_vec(4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 5'b01100, 1'b0);
    push(1, 1'b0, 4, 0, 0, 1'b0, 3'b000, 2'b10); tick();
    set_vec(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'b00010, 1'b0);
    tick(); iv[1] = 1'b0; tick();
    check("u1_done", {61'd0, o_done[1], o_st[1]}, 64'b110);
    check("u1_pc", {48'd0, o_pc[1]}, 64'd4);

    // Instance 2: CNT_W=2 saturation, bypass cases, parity-only difference
    stt[2] = 1'b1; tick(); stt[2] = 1'b0;
    iv[2] = 1'b1;
    set_vec(4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 5'b11110, 1'b0);
    push(2, 1'b0, 1, 0, 0, 1'b0, 3'b000, 2'b01); tick();
    set_vec(4'b0000, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 5'b00110, 1'b0);
    push(2, 1'b0, 2, 0, 0, 1'b0, 3'b000, 2'b01); tick();
    set_vec(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'b00001, 1'b0);
    push(2, 1'b0, 3, 0, 0, 1'b0, 3'b000, 2'b01); tick();
    set_vec(4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 5'b01100, 1'b0);
    push(2, 1'b0, 3, 0, 0, 1'b0, 3'b000, 2'b01); tick();
    set_vec(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'b11111, 1'b0);
    push(2, 1'b0, 3, 0, 0, 1'b0, 3'b000, 2'b01); tick();
    set_vec(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 5'b01010, 1'b0);
    dpar = 1'b1;
`ifdef ALU_CHK_PARITY_EN
    push(2, 1'b1, 3, 1, 0, 1'b1, 3'b111, 2'b01);
`else
    push(2, 1'b0, 3, 0, 0, 1'b0, 3'b000, 2'b01);
`endif
    tick();

    // Reset while a transaction is presented: no compare may follow
    set_vec(4'b0011, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'b01001, 1'b0);
    rst = 1'b1; tick();
    check("u2_rst_mid",
          {o_cv[2], o_mis[2], o_err[2], o_done[2], o_pc[2], o_fc[2], o_ic[2], o_lop[2], o_st[2]},
          64'd0);
    rst = 1'b0; iv[2] = 1'b0;
    tick(); tick();
    check("q0_left", 64'(q0.size()), 64'd0);
    check("q1_left", 64'(q1.size()), 64'd0);
    check("q2_left", 64'(q2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
